// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  // Next-PC select from execute; 2'b11 is reserved and behaves as PC_SEQ.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Redirect address: JALR clears bit 0, and fetches are always word aligned.
  function automatic logic [XLEN-1:0] redirect_addr(input logic [1:0] src,
                                                    input logic [XLEN-1:0] tgt);
    logic [XLEN-1:0] t;
    t = (src == PC_JALR) ? (tgt & 32'hFFFF_FFFE) : tgt;
    return t & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// Single-entry skid buffer holding a response that decode could not take.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         occupied
);

  // Drop wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= 1'b0;
      dout     <= '0;
    end else if (drop) begin
      occupied <= 1'b0;
    end else if (load) begin
      occupied <= 1'b1;
      dout     <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, skid buffer, redirect drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic [1:0]      pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            req, req_n;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            load_mem, load_skid, skid_load, skid_drop, skid_occ;
  fetch_entry_t    skid_q, ld;

  assign redirect = (pc_src_e == PC_BR) || (pc_src_e == PC_JALR);
  assign target   = redirect_addr(pc_src_e, pc_target_e);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  assign ld = load_skid ? skid_q : fetch_entry_t'{instr: imem.imem_rdata, pc: pc};

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .drop     (skid_drop),
    .din      (fetch_entry_t'{instr: imem.imem_rdata, pc: pc}),
    .dout     (skid_q),
    .occupied (skid_occ)
  );

  // State, PC and request registers; reset leaves no request outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_VECTOR;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      req   <= req_n;
    end
  end

  // Next-state logic; a response only counts while our own request is up.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = req;
    load_mem  = 1'b0;
    load_skid = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_n      = target;
          skid_drop = 1'b1;
          if (req && !imem.imem_valid) begin
            state_n = DRAIN;
            req_n   = 1'b0;
          end else begin
            req_n = 1'b1;
          end
        end else if (req && imem.imem_valid) begin
          if (stall_d) begin
            skid_load = 1'b1;
            req_n     = 1'b0;
            state_n   = HOLD;
          end else begin
            load_mem = 1'b1;
            pc_n     = pc + XLEN'(4);
          end
        end else begin
          req_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n      = target;
          skid_drop = 1'b1;
          req_n     = 1'b1;
          state_n   = FETCH;
        end else if (!stall_d && skid_occ) begin
          load_skid = 1'b1;
          skid_drop = 1'b1;
          pc_n      = pc + XLEN'(4);
          req_n     = 1'b1;
          state_n   = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) pc_n = target;
        if (imem.imem_valid) begin
          req_n   = 1'b1;
          state_n = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // Decode registers; an empty slot always carries the NOP encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      pcplus4_d <= '0;
    end else if (redirect) begin
      valid_d <= 1'b0;
      instr_d <= NOP_INSTR;
    end else if (load_mem || load_skid) begin
      pc_d      <= ld.pc;
      pcplus4_d <= ld.pc + XLEN'(4);
      valid_d   <= !flush_d;
      instr_d   <= flush_d ? NOP_INSTR : ld.instr;
    end else if (flush_d || !stall_d) begin
      // Flushed, or decode consumed the instruction and nothing new arrived.
      valid_d <= 1'b0;
      instr_d <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d, flush_d;
  logic [1:0]  pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state: one pending request, data = ~address.
  int          lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic        mem_valid_q = 1'b0;
  logic [31:0] mem_paddr = 32'h0;
  logic        stale = 1'b0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (imem),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d)
  );

  always #5 clk = ~clk;

  assign imem.imem_valid = mem_valid_q | stale;
  assign imem.imem_rdata = ~mem_paddr;

  // Memory: latches a request, answers after lat cycles, keeps answering a drained request.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      mem_pend    = 1'b0;
      mem_cnt     = 0;
      mem_valid_q = 1'b0;
    end else begin
      if (mem_valid_q) mem_pend = 1'b0;
      if (!mem_pend && imem.imem_req) begin
        mem_pend  = 1'b1;
        mem_cnt   = 0;
        mem_paddr = imem.imem_addr;
      end
      if (mem_pend) mem_cnt++;
      mem_valid_q = mem_pend && (mem_cnt >= lat);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 2'b00; pc_target_e = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req",     32'(imem.imem_req), 32'd0);
    check_eq("rst_valid",   32'(valid_d), 32'd0);
    check_eq("rst_instr",   instr_d, 32'h0000_0013);
    check_eq("rst_pc_d",    pc_d, 32'h0);
    check_eq("rst_pcplus4", pcplus4_d, 32'h0);
    check_eq("rst_addr",    imem.imem_addr, 32'hBFC0_0000);
    rst = 1'b0;

    // Streaming with single-cycle memory
    @(negedge clk);
    check_eq("s1_c1_req",   32'(imem.imem_req), 32'd1);
    check_eq("s1_c1_addr",  imem.imem_addr, 32'hBFC0_0000);
    check_eq("s1_c1_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    check_eq("s1_c2_addr",  imem.imem_addr, 32'hBFC0_0004);
    check_eq("s1_c2_valid", 32'(valid_d), 32'd1);
    check_eq("s1_c2_instr", instr_d, 32'h403F_FFFF);
    check_eq("s1_c2_pc",    pc_d, 32'hBFC0_0000);
    check_eq("s1_c2_pc4",   pcplus4_d, 32'hBFC0_0004);
    @(negedge clk);
    check_eq("s1_c3_addr",  imem.imem_addr, 32'hBFC0_0008);
    check_eq("s1_c3_pc",    pc_d, 32'hBFC0_0004);

    // Stall while BFC00004 returns, flush in HOLD, then release
    do_reset();
    @(negedge clk);
    @(negedge clk);
    stall_d = 1'b1;
    @(negedge clk);
    check_eq("s2_hold_req",   32'(imem.imem_req), 32'd0);
    check_eq("s2_hold_valid", 32'(valid_d), 32'd1);
    check_eq("s2_hold_pc",    pc_d, 32'hBFC0_0000);
    check_eq("s2_hold_addr",  imem.imem_addr, 32'hBFC0_0004);
    @(negedge clk);
    flush_d = 1'b1;
    @(negedge clk);
    flush_d = 1'b0;
    stall_d = 1'b0;
    check_eq("s2_flush_valid", 32'(valid_d), 32'd0);
    check_eq("s2_flush_instr", instr_d, 32'h0000_0013);
    @(negedge clk);
    check_eq("s2_rel_instr", instr_d, 32'h403F_FFFB);
    check_eq("s2_rel_pc",    pc_d, 32'hBFC0_0004);
    check_eq("s2_rel_pc4",   pcplus4_d, 32'hBFC0_0008);
    check_eq("s2_rel_addr",  imem.imem_addr, 32'hBFC0_0008);
    check_eq("s2_rel_req",   32'(imem.imem_req), 32'd1);
    check_eq("s2_rel_valid", 32'(valid_d), 32'd1);

    // Branch redirect with request outstanding, latency 3
    lat = 3;
    do_reset();
    @(negedge clk);
    pc_src_e = 2'b01; pc_target_e = 32'hBFC0_0040;
    @(negedge clk);
    pc_src_e = 2'b00;
    check_eq("s3_drain_req",   32'(imem.imem_req), 32'd0);
    check_eq("s3_drain_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("s3_new_req",   32'(imem.imem_req), 32'd1);
    check_eq("s3_new_addr",  imem.imem_addr, 32'hBFC0_0040);
    check_eq("s3_new_valid", 32'(valid_d), 32'd0);
    check_eq("s3_new_instr", instr_d, 32'h0000_0013);
    repeat (2) @(negedge clk);
    check_eq("s3_wait_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    check_eq("s3_ret_valid", 32'(valid_d), 32'd1);
    check_eq("s3_ret_instr", instr_d, 32'h403F_FFBF);
    check_eq("s3_ret_pc",    pc_d, 32'hBFC0_0040);

    // JALR alignment, redirect with same-cycle response
    lat = 1;
    do_reset();
    @(negedge clk);
    pc_src_e = 2'b10; pc_target_e = 32'hBFC0_0103;
    @(negedge clk);
    pc_src_e = 2'b00;
    check_eq("s4_jalr_addr",  imem.imem_addr, 32'hBFC0_0100);
    check_eq("s4_jalr_req",   32'(imem.imem_req), 32'd1);
    check_eq("s4_jalr_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    check_eq("s4_ld_instr", instr_d, 32'h403F_FEFF);
    check_eq("s4_ld_pc",    pc_d, 32'hBFC0_0100);
    check_eq("s4_ld_pc4",   pcplus4_d, 32'hBFC0_0104);

    // Redirect together with stall: redirect wins
    stall_d = 1'b1; pc_src_e = 2'b01; pc_target_e = 32'hBFC0_0200;
    @(negedge clk);
    stall_d = 1'b0;
    check_eq("s5_valid", 32'(valid_d), 32'd0);
    check_eq("s5_instr", instr_d, 32'h0000_0013);
    check_eq("s5_addr",  imem.imem_addr, 32'hBFC0_0200);

    // PC wrap at the top of the address space
    pc_src_e = 2'b01; pc_target_e = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_src_e = 2'b00;
    check_eq("s6_top_addr",  imem.imem_addr, 32'hFFFF_FFFC);
    check_eq("s6_top_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    check_eq("s6_wrap_pc",    pc_d, 32'hFFFF_FFFC);
    check_eq("s6_wrap_pc4",   pcplus4_d, 32'h0);
    check_eq("s6_wrap_addr",  imem.imem_addr, 32'h0);
    check_eq("s6_wrap_instr", instr_d, 32'h0000_0003);

    // Reset mid-transaction followed by a stale response strobe
    lat = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    check_eq("s7_req",   32'(imem.imem_req), 32'd1);
    check_eq("s7_addr",  imem.imem_addr, 32'hBFC0_0000);
    check_eq("s7_valid", 32'(valid_d), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("s7_wait_valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    check_eq("s7_ld_valid", 32'(valid_d), 32'd1);
    check_eq("s7_ld_pc",    pc_d, 32'hBFC0_0000);
    check_eq("s7_ld_instr", instr_d, 32'h403F_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 stall_d  in  1  decode stage cannot accept a new instruction this cycle.
REQ-005 flush_d  in  1  invalidate the instruction currently held for decode.
REQ-006 pc_src_e  in  2  next-PC select from execute: 00 sequential, 01 branch/JAL target, 10 JALR target, 11 reserved (treated as 00).
REQ-007 pc_target_e  in  32  redirect address from execute.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_valid  in  1  response strobe, one per request, at least 1 cycle after request.
REQ-011 imem_rdata  in  32  instruction word, valid when imem_valid=1.
REQ-012 instr_d, pc_d, pcplus4_d  out  32 each  instruction, its address and address+4 presented to decode (opcode = instr_d[6:0]).
REQ-013 valid_d  out  1  instr_d/pc_d/pcplus4_d hold a live instruction.

Function
REQ-014 SHALL keep at most one memory request outstanding; imem_req held high with stable imem_addr until imem_valid.
REQ-015 SHALL implement states FETCH (request outstanding), HOLD (response captured in skid buffer while stall_d=1), DRAIN (outstanding response to be discarded after redirect).
REQ-016 FETCH, imem_valid=1, stall_d=0, no redirect: load instr_d/pc_d/pcplus4_d, valid_d<=1, PC<=PC+4, next request issued the following cycle without a bubble (imem_req remains 1, imem_addr updates).
REQ-017 FETCH, imem_valid=1, stall_d=1: capture response into skid buffer, deassert imem_req, go HOLD; decode outputs unchanged.
REQ-018 HOLD, stall_d=0: move buffer to decode outputs, valid_d<=1, PC<=PC+4, reassert imem_req, go FETCH.
REQ-019 Redirect (pc_src_e=01 or 10) SHALL take priority over stall_d: PC<=pc_target_e, valid_d<=0, skid buffer dropped.
REQ-020 Redirect in FETCH with imem_valid=0: go DRAIN, imem_req low; on imem_valid discard data, issue request at new PC next cycle, go FETCH.
REQ-021 Redirect in FETCH with imem_valid=1 in same cycle: discard response, request new PC next cycle, stay FETCH.
REQ-022 Redirect during DRAIN: update PC only; single pending response still discarded.
REQ-023 pc_src_e=10 SHALL clear target bit 0; imem_addr[1:0] SHALL always be 00 (target bits [1:0] ignored, no exception).
REQ-024 flush_d=1 without redirect: valid_d<=0; fetch progress and skid buffer unaffected; flush_d with simultaneous load clears the loaded instruction.
REQ-025 valid_d=0 SHALL force instr_d to 32'h0000_0013 (NOP) so decode sees an R/I-type with no side effects.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-027 While rst=1: PC<=RESET_VECTOR, state<=FETCH, imem_req<=0, valid_d<=0, instr_d<=NOP, pc_d<=0, pcplus4_d<=0, skid buffer empty.
REQ-028 First cycle after rst falls: imem_req=1, imem_addr=RESET_VECTOR.
REQ-029 rst mid-transaction SHALL abandon the outstanding response; a stale imem_valid in the first post-reset cycle before any request SHALL be ignored.

Structure
REQ-030 Shared package SHALL hold pc_src enum (PC_SEQ, PC_BR, PC_JALR), fetch state enum, NOP_INSTR and RESET_VECTOR default.
REQ-031 Skid buffer (data, pc, occupied flag) SHALL be one sub-module, fetch_skid.

Verification
REQ-032 Reset, 1-cycle memory, no stalls -> imem_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; valid_d=1 from cycle 2.
REQ-033 stall_d=1 for 3 cycles while response at BFC00004 arrives -> imem_req low, HOLD; on release instr_d=that word, pc_d=BFC00004, next addr BFC00008.
REQ-034 pc_src_e=01, target=BFC00040 while request outstanding, memory latency 3 -> old response dropped, next imem_addr=BFC00040, valid_d=0 until it returns.
REQ-035 pc_src_e=10, target=BFC00103 -> imem_addr=BFC00100.
REQ-036 Redirect and stall_d=1 in same cycle -> redirect wins, valid_d=0, instr_d=00000013.
REQ-037 rst asserted with request outstanding, stale imem_valid after release -> ignored, first pc_d=BFC00000.
